// File: rtl/piso_shift_feeder.sv
// Purpose: parallel-in/serial-out feeder that streams each accepted word MSB
//          first into a downstream SIPO stage, with a one-word holding buffer.
// Latency: one cycle from acceptance into an idle block to the first strobe.
// Backpressure: in_ready = !hold_full; a word arriving while one shifts waits in hold.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word
//   in_data    parallel word, WIDTH bits
//   in_ready   word can be accepted this cycle
//   shift_out  serial bit for the downstream ShiftIn
//   shift_en   strobe for the downstream ShiftEn
//   word_done  one-cycle pulse after the last strobe of each word
//   busy       serializing, in gap, or holding a word
//
// Optional feature: define SER_PARITY_EN to append an even-parity strobe after
// each word (the downstream register is then WIDTH+1 bits).
module piso_shift_feeder #(
  parameter int WIDTH    = 4,
  parameter int IDLE_GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             shift_out,
  output logic             shift_en,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;
  localparam logic          HAS_GAP  = (IDLE_GAP > 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
`ifdef SER_PARITY_EN
  logic             par_acc;   // running XOR of the bits already shifted out
`endif

  logic accept;
  logic last_bit;
  logic gap_last;
  logic word_end;   // this cycle carries the final strobe of the word
  logic load_next;

  assign accept   = in_valid && !hold_full;
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign gap_last = (state == ST_GAP) && (gap_cnt == GAP_LAST);
`ifdef SER_PARITY_EN
  assign word_end = (state == ST_PAR);
`else
  assign word_end = last_bit;
`endif
  // Without a gap the next word is picked up straight after the final strobe,
  // which keeps shift_en continuous when hold is kept full.
  assign load_next = gap_last || (word_end && !HAS_GAP);

  assign in_ready = !hold_full;
  assign busy     = (state != ST_IDLE) || hold_full;

  always_comb begin
    shift_en  = 1'b0;
    shift_out = 1'b0;
    case (state)
      ST_SHIFT: begin
        shift_en  = 1'b1;
        shift_out = shreg[WIDTH-1];
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        shift_en  = 1'b1;
        shift_out = par_acc;
      end
`endif
      default: begin
        shift_en  = 1'b0;
        shift_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      word_done <= 1'b0;
`ifdef SER_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      word_done <= word_end;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
`ifdef SER_PARITY_EN
            par_acc <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
`ifdef SER_PARITY_EN
          par_acc <= par_acc ^ shreg[WIDTH-1];
          if (last_bit) state <= ST_PAR;
`else
          if (last_bit && HAS_GAP) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
`endif
        end
`ifdef SER_PARITY_EN
        ST_PAR: begin
          if (HAS_GAP) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
`endif
        ST_GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= ST_IDLE;
      endcase

      // A word offered while busy parks in hold, unless this edge is already
      // picking up the next word, in which case it bypasses straight to shreg.
      if (accept && (state != ST_IDLE) && !load_next) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end

      // Later assignments here take precedence over the per-state updates.
      if (load_next) begin
        if (hold_full) begin
          shreg     <= hold;
          hold_full <= 1'b0;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
`ifdef SER_PARITY_EN
          par_acc   <= 1'b0;
`endif
        end else if (accept) begin
          shreg     <= in_data;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
`ifdef SER_PARITY_EN
          par_acc   <= 1'b0;
`endif
        end else begin
          state     <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_feeder.sv
// Purpose: self-checking bench for piso_shift_feeder with gap=1 and gap=0 instances.
// Latency: expected strobe schedule built from words, gap and parity rules.
// Backpressure: second words are offered while the first shifts to exercise hold.
module tb_piso_shift_feeder;

`ifdef SER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       sel;   // 0: IDLE_GAP=1 instance, 1: IDLE_GAP=0 instance

  logic rdy1, out1, en1, done1, busy1;
  logic rdy0, out0, en0, done0, busy0;
  logic o_rdy, o_out, o_en, o_done, o_busy;
  logic [7:0] sipo;

  int checks = 0;
  int errors = 0;
  logic [3:0] wq[$];

  piso_shift_feeder #(.WIDTH(4), .IDLE_GAP(1)) u_gap1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_data(in_data),
    .in_ready(rdy1), .shift_out(out1), .shift_en(en1), .word_done(done1), .busy(busy1)
  );

  piso_shift_feeder #(.WIDTH(4), .IDLE_GAP(0)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_data(in_data),
    .in_ready(rdy0), .shift_out(out0), .shift_en(en0), .word_done(done0), .busy(busy0)
  );

  assign o_rdy  = sel ? rdy0  : rdy1;
  assign o_out  = sel ? out0  : out1;
  assign o_en   = sel ? en0   : en1;
  assign o_done = sel ? done0 : done1;
  assign o_busy = sel ? busy0 : busy1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream left-shifting SIPO register.
  always_ff @(posedge clk) if (o_en) sipo <= {sipo[6:0], o_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // j-th serial bit of a word: data MSB first, then the even parity bit.
  function automatic logic exp_bit(input logic [3:0] w, input int j);
    logic [3:0] tmp;
    tmp = w;
    if (j < 4) return tmp[3-j];
    return ^tmp;
  endfunction

  function automatic logic [7:0] stream_val(input logic [3:0] w);
    logic [7:0] v;
    v = 8'(w);
    if (NB == 5) v = {v[6:0], ^w};
    return v;
  endfunction

  // Offers every word in wq as early as in_ready allows and checks the
  // cycle-by-cycle strobe schedule the words, gap and parity imply.
  task automatic run_stream();
    int n, gap, t, idx, cycles, active;
    logic en_e[64];
    logic out_e[64];
    logic done_e[64];
    logic rdy_now;
    logic [7:0] mask;
    n   = wq.size();
    gap = sel ? 0 : 1;
    for (int i = 0; i < 64; i++) begin
      en_e[i] = 1'b0; out_e[i] = 1'b0; done_e[i] = 1'b0;
    end
    t = 0;
    foreach (wq[k]) begin
      for (int j = 0; j < NB; j++) begin
        en_e[t]  = 1'b1;
        out_e[t] = exp_bit(wq[k], j);
        t++;
      end
      done_e[t] = 1'b1;
      t += gap;
    end
    active = t;
    cycles = active + 2;

    check("in_ready_idle", 32'(o_rdy), 1);
    in_data  = wq[0];
    in_valid = 1'b1;
    idx      = 1;
    step();
    for (int c = 0; c < cycles; c++) begin
      if (idx < n) begin
        in_valid = 1'b1;
        in_data  = wq[idx];
      end else begin
        in_valid = 1'b0;
      end
      check("shift_en",  32'(o_en),   32'(en_e[c]));
      check("shift_out", 32'(o_out),  32'(out_e[c]));
      check("word_done", 32'(o_done), 32'(done_e[c]));
      check("busy",      32'(o_busy), 32'(c < active));
      rdy_now = o_rdy;
      step();
      if (in_valid && rdy_now) begin
        idx++;
        check("in_ready_hold_full", 32'(o_rdy), 0);
      end
    end
    in_valid = 1'b0;
    check("all_accepted", idx, n);
    mask = 8'((1 << NB) - 1);
    check("sipo_parallel_out", 32'(sipo & mask), 32'(stream_val(wq[n-1])));
  endtask

  initial begin
    int strobes;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    sel      = 1'b0;
    step();
    step();
    check("rst_in_ready",  32'(o_rdy),  1);
    check("rst_shift_en",  32'(o_en),   0);
    check("rst_shift_out", 32'(o_out),  0);
    check("rst_word_done", 32'(o_done), 0);
    check("rst_busy",      32'(o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word, gap of one.
    sel = 1'b0;
    wq = {4'b1011};
    run_stream();
    // Second word held while the first shifts.
    wq = {4'hA, 4'h5};
    run_stream();
    // No gap: back-to-back words with continuous strobes.
    sel = 1'b1;
    wq = {4'hC, 4'h3};
    run_stream();
    // Odd and even parity words.
    sel = 1'b0;
    wq = {4'b0111};
    run_stream();
    wq = {4'b0110};
    run_stream();

    // Random word bursts on both instances.
    for (int r = 0; r < 8; r++) begin
      int nw;
      sel = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back(4'($urandom_range(0, 15)));
      run_stream();
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset in the middle of a word, with another word held.
    sel      = 1'b0;
    in_data  = 4'hF;
    in_valid = 1'b1;
    step();
    in_data  = 4'h9;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_shift_en",  32'(o_en),   0);
    check("midrst_shift_out", 32'(o_out),  0);
    check("midrst_busy",      32'(o_busy), 0);
    check("midrst_in_ready",  32'(o_rdy),  1);
    check("midrst_word_done", 32'(o_done), 0);
    check("midrst_two_bits",  32'(sipo[1:0]), 3);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_en) strobes++;
    end
    check("postrst_no_strobes", strobes, 0);
    check("postrst_busy", 32'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
